// File: rtl/button_conditioner.sv
// button_conditioner
// Purpose: turns raw, bouncy push-button levels into clean debounced levels,
//          single-cycle press/release pulses and optional auto-repeat presses.
//          Every channel is independent: 2-flop synchronizer plus its own FSM.
// Ports:
//   clk          fpga clock
//   reset        asynchronous, active-high reset
//   btn_raw      raw button levels (asynchronous, bouncy)
//   repeat_en    per-channel auto-repeat enable (synchronous to clk)
//   btn_level    debounced button level (registered)
//   btn_press    1-cycle pulse on accepted press and each auto-repeat (registered)
//   btn_release  1-cycle pulse on accepted release (registered)
module button_conditioner #(
  parameter int unsigned WIDTH           = 3,
  parameter int unsigned CNT_W           = 25,
  parameter int unsigned DEBOUNCE_CYCLES = 500000,
  parameter int unsigned REPEAT_DELAY    = 25000000,
  parameter int unsigned REPEAT_PERIOD   = 5000000
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] btn_raw,
  input  logic [WIDTH-1:0] repeat_en,
  output logic [WIDTH-1:0] btn_level,
  output logic [WIDTH-1:0] btn_press,
  output logic [WIDTH-1:0] btn_release
);

  // Terminal counts: a counting state transitions when cnt reaches limit-1.
  localparam logic [CNT_W-1:0] DB_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] RD_LAST = CNT_W'(REPEAT_DELAY - 1);
  localparam logic [CNT_W-1:0] RP_LAST = CNT_W'(REPEAT_PERIOD - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_PRESS_DB,
    S_HELD,
    S_REPEAT,
    S_RELEASE_DB
  } state_t;

  logic [WIDTH-1:0] r_sync1;
  logic [WIDTH-1:0] r_sync2;

  // Two-flop synchronizer; the FSMs only ever see r_sync2.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_sync1 <= '0;
      r_sync2 <= '0;
    end else begin
      r_sync1 <= btn_raw;
      r_sync2 <= r_sync1;
    end
  end

  for (genvar g = 0; g < WIDTH; g++) begin : g_ch
    state_t           r_state;
    state_t           w_state_nxt;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_cnt_nxt;
    logic             r_level;
    logic             r_press;
    logic             r_release;
    logic             w_level_nxt;
    logic             w_press_nxt;
    logic             w_release_nxt;
    logic             w_btn_s;
    logic             w_rep_en;
    logic             w_db_done;
    logic             w_rd_done;
    logic             w_rp_done;

    assign w_btn_s   = r_sync2[g];
    assign w_rep_en  = repeat_en[g];
    assign w_db_done = (r_cnt == DB_LAST);
    assign w_rd_done = (r_cnt == RD_LAST);
    assign w_rp_done = (r_cnt == RP_LAST);

    // State, counter and output registers.
    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        r_state   <= S_IDLE;
        r_cnt     <= '0;
        r_level   <= 1'b0;
        r_press   <= 1'b0;
        r_release <= 1'b0;
      end else begin
        r_state   <= w_state_nxt;
        r_cnt     <= w_cnt_nxt;
        r_level   <= w_level_nxt;
        r_press   <= w_press_nxt;
        r_release <= w_release_nxt;
      end
    end

    // Next state and counter; every exit from a counting state clears cnt.
    always_comb begin
      w_state_nxt = r_state;
      w_cnt_nxt   = r_cnt;
      case (r_state)
        S_IDLE: begin
          w_cnt_nxt = '0;
          if (w_btn_s) w_state_nxt = S_PRESS_DB;
        end
        S_PRESS_DB: begin
          if (!w_btn_s) begin
            w_state_nxt = S_IDLE;
            w_cnt_nxt   = '0;
          end else if (w_db_done) begin
            w_state_nxt = S_HELD;
            w_cnt_nxt   = '0;
          end else begin
            w_cnt_nxt = r_cnt + CNT_W'(1);
          end
        end
        S_HELD: begin
          if (!w_btn_s) begin
            w_state_nxt = S_RELEASE_DB;
            w_cnt_nxt   = '0;
          end else if (!w_rep_en) begin
            w_cnt_nxt = '0;
          end else if (w_rd_done) begin
            w_state_nxt = S_REPEAT;
            w_cnt_nxt   = '0;
          end else begin
            w_cnt_nxt = r_cnt + CNT_W'(1);
          end
        end
        S_REPEAT: begin
          if (!w_btn_s) begin
            w_state_nxt = S_RELEASE_DB;
            w_cnt_nxt   = '0;
          end else if (!w_rep_en) begin
            w_state_nxt = S_HELD;
            w_cnt_nxt   = '0;
          end else if (w_rp_done) begin
            w_cnt_nxt = '0;
          end else begin
            w_cnt_nxt = r_cnt + CNT_W'(1);
          end
        end
        S_RELEASE_DB: begin
          if (w_btn_s) begin
            w_state_nxt = S_HELD;
            w_cnt_nxt   = '0;
          end else if (w_db_done) begin
            w_state_nxt = S_IDLE;
            w_cnt_nxt   = '0;
          end else begin
            w_cnt_nxt = r_cnt + CNT_W'(1);
          end
        end
        default: begin
          w_state_nxt = S_IDLE;
          w_cnt_nxt   = '0;
        end
      endcase
    end

    // Next output values; press and release come from disjoint states.
    always_comb begin
      w_press_nxt   = 1'b0;
      w_release_nxt = 1'b0;
      w_level_nxt   = 1'b0;
      if (w_btn_s) begin
        w_press_nxt = ((r_state == S_PRESS_DB) && w_db_done) ||
                      ((r_state == S_HELD)   && w_rep_en && w_rd_done) ||
                      ((r_state == S_REPEAT) && w_rep_en && w_rp_done);
      end
      w_release_nxt = (r_state == S_RELEASE_DB) && !w_btn_s && w_db_done;
      // Level is high in every state that follows an accepted press.
      w_level_nxt   = (w_state_nxt == S_HELD) || (w_state_nxt == S_REPEAT) ||
                      (w_state_nxt == S_RELEASE_DB);
    end

    assign btn_level[g]   = r_level;
    assign btn_press[g]   = r_press;
    assign btn_release[g] = r_release;
  end

endmodule
